// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback stage: FSM state encoding,
// the MEM/WB pipeline register layout and the jump-target width.
package wb_pkg;

  localparam int WB_REGI_BITS = 4;
  localparam int WB_VECT_BITS = 2;
  localparam int WB_REGI_SIZE = 16;
  localparam int WB_ELEM_SIZE = 8;
  localparam int WB_VECT_SIZE = 8;
  localparam int WB_VEC_WIDTH = WB_ELEM_SIZE * WB_VECT_SIZE;
  localparam int JUMP_BITS    = 10;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    HALTED = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic                    valid;
    logic [WB_VEC_WIDTH-1:0] memRd;
    logic [WB_ELEM_SIZE-1:0] aluInt;
    logic [WB_VEC_WIDTH-1:0] aluVec;
    logic                    flagMemRead;
    logic                    writeResultInt;
    logic                    writeResultV;
    logic [WB_REGI_BITS-1:0] intRegDest;
    logic [WB_VECT_BITS-1:0] vecRegDest;
    logic                    enableJump;
    logic [JUMP_BITS-1:0]    jumpAddress;
    logic                    flagEnd;
    logic                    flagNop;
  } mem_wb_t;

endpackage

// File: rtl/wb_squash_ctrl.sv
// Writeback control FSM: commits in RUN, discards wrong-path instructions
// in SQUASH after a taken jump, and parks in HALTED after an end instruction.
module wb_squash_ctrl
  import wb_pkg::*;
#(
  parameter int SQUASH_DEPTH = 3
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      commit,
  input  logic      jump,
  input  logic      isEnd,
  input  logic      valid,
  input  logic      stall,
  output wb_state_t state,
  output logic      pcSel,
  output logic      discard
);

  localparam logic [2:0] DEPTH = 3'(SQUASH_DEPTH);

  wb_state_t  stateNext;
  logic [2:0] squashCnt;
  logic [2:0] squashCntNext;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= RUN;
      squashCnt <= '0;
    end else begin
      state     <= stateNext;
      squashCnt <= squashCntNext;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    stateNext     = state;
    squashCntNext = squashCnt;
    pcSel         = 1'b0;
    discard       = 1'b0;
    unique case (state)
      RUN: begin
        if (commit) begin
          if (isEnd) begin
            stateNext = HALTED;
          end else if (jump) begin
            pcSel = 1'b1;
            if (DEPTH != 3'd0) begin
              squashCntNext = DEPTH;
              stateNext     = SQUASH;
            end
          end
        end
      end
      SQUASH: begin
        // Only real instructions count against the squash window; bubbles pass.
        if (valid && !stall) begin
          discard       = 1'b1;
          squashCntNext = squashCnt - 3'd1;
          if (squashCnt <= 3'd1) begin
            squashCntNext = '0;
            stateNext     = RUN;
          end
        end
      end
      HALTED: begin
        stateNext = HALTED;
      end
      default: begin
        stateNext     = RUN;
        squashCntNext = '0;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, writeback data select, register-file
// write ports and PC redirect. Optional retired counter: WB_RETIRE_CNT_EN.
module wb_stage
  import wb_pkg::*;
#(
  parameter int REGI_BITS    = WB_REGI_BITS,
  parameter int VECT_BITS    = WB_VECT_BITS,
  parameter int REGI_SIZE    = WB_REGI_SIZE,
  parameter int ELEM_SIZE    = WB_ELEM_SIZE,
  parameter int VECT_SIZE    = WB_VECT_SIZE,
  parameter int SQUASH_DEPTH = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           valid_i,
  input  logic                           stall_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] mem_rd_i,
  input  logic [ELEM_SIZE-1:0]           alu_int_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] alu_vec_i,
  input  logic                           flagMemRead_i,
  input  logic                           writeResultInt_i,
  input  logic                           writeResultV_i,
  input  logic [REGI_BITS-1:0]           intRegDest_i,
  input  logic [VECT_BITS-1:0]           vecRegDest_i,
  input  logic                           enableJump_i,
  input  logic [JUMP_BITS-1:0]           jumpAddress_i,
  input  logic                           flagEnd_i,
  input  logic                           flagNop_i,
  output logic                           int_we_o,
  output logic [REGI_BITS-1:0]           int_dest_o,
  output logic [REGI_SIZE-1:0]           int_wd_o,
  output logic                           vec_we_o,
  output logic [VECT_BITS-1:0]           vec_dest_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] vec_wd_o,
  output logic                           pc_sel_o,
  output logic [REGI_SIZE-1:0]           pc_target_o,
  output logic                           halted_o,
  output logic [31:0]                    retired_o
);

  // The register layout comes from wb_pkg; the width parameters above must
  // keep their package defaults.
  mem_wb_t   r;
  wb_state_t state;
  logic      commit;
  logic      discard;
  logic      pcSel;
  logic      writeOk;

  // NOTE: this is a pipeline register, not a storage array, so every field
  // is reset; that is what makes all outputs read zero during reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r <= '0;
    end else if (!stall_i) begin
      r.valid          <= valid_i;
      r.memRd          <= mem_rd_i;
      r.aluInt         <= alu_int_i;
      r.aluVec         <= alu_vec_i;
      r.flagMemRead    <= flagMemRead_i;
      r.writeResultInt <= writeResultInt_i;
      r.writeResultV   <= writeResultV_i;
      r.intRegDest     <= intRegDest_i;
      r.vecRegDest     <= vecRegDest_i;
      r.enableJump     <= enableJump_i;
      r.jumpAddress    <= jumpAddress_i;
      r.flagEnd        <= flagEnd_i;
      r.flagNop        <= flagNop_i;
    end
  end

  assign commit = r.valid & ~stall_i & (state == RUN);

  wb_squash_ctrl #(
    .SQUASH_DEPTH(SQUASH_DEPTH)
  ) u_ctrl (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .commit (commit),
    .jump   (r.enableJump),
    .isEnd  (r.flagEnd),
    .valid  (r.valid),
    .stall  (stall_i),
    .state  (state),
    .pcSel  (pcSel),
    .discard(discard)
  );

  // commit and discard never overlap; gating on both keeps the squash
  // decision owned by the controller alone.
  assign writeOk = commit & ~discard & ~r.flagNop;

  assign int_we_o    = writeOk & r.writeResultInt;
  assign vec_we_o    = writeOk & r.writeResultV;
  assign int_dest_o  = r.intRegDest;
  assign vec_dest_o  = r.vecRegDest;
  assign int_wd_o    = r.flagMemRead ? r.memRd[REGI_SIZE-1:0] : REGI_SIZE'(r.aluInt);
  assign vec_wd_o    = r.flagMemRead ? r.memRd : r.aluVec;
  assign pc_sel_o    = pcSel;
  assign pc_target_o = REGI_SIZE'(r.jumpAddress);
  assign halted_o    = (state == HALTED);

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retiredCnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      retiredCnt <= '0;
    end else if (writeOk) begin
      retiredCnt <= retiredCnt + 32'd1;
    end
  end

  assign retired_o = retiredCnt;
`else
  assign retired_o = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, hand-written
// jump/stall/end/reset sequences, and random traffic against a rule model.
module tb_wb_stage;

  localparam int SQUASH_DEPTH = 3;

  typedef struct packed {
    logic        v;
    logic [63:0] memRd;
    logic [7:0]  aluInt;
    logic [63:0] aluVec;
    logic        mr;
    logic        wi;
    logic        wv;
    logic [3:0]  id;
    logic [1:0]  vd;
    logic        jmp;
    logic [9:0]  ja;
    logic        en;
    logic        nop;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic        intWe;
    logic [3:0]  intDest;
    logic [15:0] intWd;
    logic        vecWe;
    logic [1:0]  vecDest;
    logic [63:0] vecWd;
  } vec_t;

  logic   clk_i = 1'b0;
  logic   rst_i = 1'b0;
  logic   stall = 1'b0;
  instr_t cur   = '0;

  logic        int_we_o, vec_we_o, pc_sel_o, halted_o;
  logic [3:0]  int_dest_o;
  logic [1:0]  vec_dest_o;
  logic [15:0] int_wd_o, pc_target_o;
  logic [63:0] vec_wd_o;
  logic [31:0] retired_o;

  int nChecks = 0;
  int nErrors = 0;

  // Rule model: the instruction sitting in writeback, how many younger
  // instructions still have to be thrown away, halt flag, retire tally.
  instr_t      mHeld;
  int          mSkip;
  logic        mHalted;
  logic [31:0] mRetired;

  always #5 clk_i = ~clk_i;

  wb_stage #(.SQUASH_DEPTH(SQUASH_DEPTH)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .valid_i         (cur.v),
    .stall_i         (stall),
    .mem_rd_i        (cur.memRd),
    .alu_int_i       (cur.aluInt),
    .alu_vec_i       (cur.aluVec),
    .flagMemRead_i   (cur.mr),
    .writeResultInt_i(cur.wi),
    .writeResultV_i  (cur.wv),
    .intRegDest_i    (cur.id),
    .vecRegDest_i    (cur.vd),
    .enableJump_i    (cur.jmp),
    .jumpAddress_i   (cur.ja),
    .flagEnd_i       (cur.en),
    .flagNop_i       (cur.nop),
    .int_we_o        (int_we_o),
    .int_dest_o      (int_dest_o),
    .int_wd_o        (int_wd_o),
    .vec_we_o        (vec_we_o),
    .vec_dest_o      (vec_dest_o),
    .vec_wd_o        (vec_wd_o),
    .pc_sel_o        (pc_sel_o),
    .pc_target_o     (pc_target_o),
    .halted_o        (halted_o),
    .retired_o       (retired_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic mr, input logic wi, input logic wv,
                                input logic [3:0] id, input logic [1:0] vd, input logic [7:0] ai,
                                input logic [63:0] av, input logic [63:0] md, input logic nop);
    instr_t t;
    t        = '0;
    t.v      = v;
    t.mr     = mr;
    t.wi     = wi;
    t.wv     = wv;
    t.id     = id;
    t.vd     = vd;
    t.aluInt = ai;
    t.aluVec = av;
    t.memRd  = md;
    t.nop    = nop;
    return t;
  endfunction

  function automatic instr_t randInstr();
    instr_t t;
    t.v      = ($urandom_range(0, 3) != 0);
    t.memRd  = {$urandom, $urandom};
    t.aluInt = 8'($urandom);
    t.aluVec = {$urandom, $urandom};
    t.mr     = 1'($urandom);
    t.wi     = 1'($urandom);
    t.wv     = 1'($urandom);
    t.id     = 4'($urandom);
    t.vd     = 2'($urandom);
    t.jmp    = ($urandom_range(0, 7) == 0);
    t.ja     = 10'($urandom);
    t.en     = ($urandom_range(0, 47) == 0);
    t.nop    = ($urandom_range(0, 5) == 0);
    return t;
  endfunction

  function automatic logic [31:0] expRetired();
`ifdef WB_RETIRE_CNT_EN
    return mRetired;
`else
    return 32'd0;
`endif
  endfunction

  task automatic checkAll(input string tag);
    logic live;
    live = mHeld.v && !stall && !mHalted && (mSkip == 0);
    check({tag, ".int_we"},  int_we_o,  live && mHeld.wi && !mHeld.nop);
    check({tag, ".vec_we"},  vec_we_o,  live && mHeld.wv && !mHeld.nop);
    check({tag, ".int_dest"}, int_dest_o, mHeld.id);
    check({tag, ".vec_dest"}, vec_dest_o, mHeld.vd);
    check({tag, ".int_wd"},  int_wd_o,  mHeld.mr ? mHeld.memRd[15:0] : {8'h00, mHeld.aluInt});
    check({tag, ".vec_wd"},  vec_wd_o,  mHeld.mr ? mHeld.memRd : mHeld.aluVec);
    check({tag, ".pc_sel"},  pc_sel_o,  live && mHeld.jmp && !mHeld.en);
    check({tag, ".pc_tgt"},  pc_target_o, {6'd0, mHeld.ja});
    check({tag, ".halted"},  halted_o,  mHalted);
    check({tag, ".retired"}, retired_o, expRetired());
  endtask

  // Advance the model by one clock edge with the currently driven inputs.
  task automatic modelStep();
    if (!stall) begin
      if (!mHalted) begin
        if (mSkip == 0) begin
          if (mHeld.v) begin
            if (!mHeld.nop) mRetired = mRetired + 32'd1;
            if (mHeld.en) mHalted = 1'b1;
            else if (mHeld.jmp) mSkip = SQUASH_DEPTH;
          end
        end else if (mHeld.v) begin
          mSkip = mSkip - 1;
        end
      end
      mHeld = cur;
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic modelReset();
    mHeld    = '0;
    mSkip    = 0;
    mHalted  = 1'b0;
    mRetired = '0;
  endtask

  task automatic doReset();
    rst_i = 1'b0;
    cur   = '0;
    stall = 1'b0;
    modelReset();
    #1;
    checkAll("reset");
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  vec_t   tbl[6];
  instr_t t;

  initial begin
    tbl[0] = '{mk(1, 0, 1, 0, 4'd3, 2'd1, 8'hA5, 64'h1111_2222_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF, 0),
               1, 4'd3, 16'h00A5, 0, 2'd1, 64'h1111_2222_3333_4444};
    tbl[1] = '{mk(1, 1, 0, 1, 4'd5, 2'd2, 8'h12, 64'h0, 64'h0123_4567_89AB_CDEF, 0),
               0, 4'd5, 16'hCDEF, 1, 2'd2, 64'h0123_4567_89AB_CDEF};
    tbl[2] = '{mk(1, 0, 1, 1, 4'd7, 2'd3, 8'h3C, 64'hDEAD_BEEF_CAFE_F00D, 64'h5, 1),
               0, 4'd7, 16'h003C, 0, 2'd3, 64'hDEAD_BEEF_CAFE_F00D};
    tbl[3] = '{mk(1, 1, 1, 1, 4'hF, 2'd1, 8'h01, 64'h9, 64'hFEDC_BA98_7654_3210, 0),
               1, 4'hF, 16'h3210, 1, 2'd1, 64'hFEDC_BA98_7654_3210};
    tbl[4] = '{mk(0, 0, 1, 1, 4'd9, 2'd0, 8'h77, 64'h0, 64'h8, 0),
               0, 4'd9, 16'h0077, 0, 2'd0, 64'h0};
    tbl[5] = '{mk(1, 0, 1, 0, 4'd0, 2'd0, 8'hFF, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 0),
               1, 4'd0, 16'h00FF, 0, 2'd0, 64'h5555_5555_5555_5555};

    doReset();

    for (int i = 0; i < 6; i++) begin
      cur = tbl[i].in;
      tick();
      check($sformatf("tbl%0d.int_we", i),   int_we_o,   tbl[i].intWe);
      check($sformatf("tbl%0d.int_dest", i), int_dest_o, tbl[i].intDest);
      check($sformatf("tbl%0d.int_wd", i),   int_wd_o,   tbl[i].intWd);
      check($sformatf("tbl%0d.vec_we", i),   vec_we_o,   tbl[i].vecWe);
      check($sformatf("tbl%0d.vec_dest", i), vec_dest_o, tbl[i].vecDest);
      check($sformatf("tbl%0d.vec_wd", i),   vec_wd_o,   tbl[i].vecWd);
      check($sformatf("tbl%0d.pc_sel", i),   pc_sel_o,   1'b0);
    end
    checkAll("tbl.end");

    // Jump to 0x2F, three squashed followers, fourth commits.
    t = mk(1, 0, 0, 0, 4'd0, 2'd0, 8'h00, 64'h0, 64'h0, 0);
    t.jmp = 1'b1;
    t.ja  = 10'h02F;
    cur = t;
    tick();
    check("jmp.pc_sel", pc_sel_o, 1'b1);
    check("jmp.target", pc_target_o, 16'h002F);
    for (int k = 0; k < 3; k++) begin
      cur = mk(1, 0, 1, 1, 4'(k + 1), 2'd1, 8'(8'h10 + k), 64'h7, 64'h0, 0);
      tick();
      check($sformatf("sq%0d.int_we", k), int_we_o, 1'b0);
      check($sformatf("sq%0d.vec_we", k), vec_we_o, 1'b0);
      check($sformatf("sq%0d.pc_sel", k), pc_sel_o, 1'b0);
    end
    cur = mk(1, 0, 1, 0, 4'd8, 2'd0, 8'h44, 64'h0, 64'h0, 0);
    tick();
    check("post_sq.int_we", int_we_o, 1'b1);
    check("post_sq.int_wd", int_wd_o, 16'h0044);
    checkAll("post_sq");

    // Stall holds a pending write for two cycles, then exactly one write.
    cur = mk(1, 0, 1, 0, 4'd6, 2'd0, 8'h42, 64'h0, 64'h0, 0);
    tick();
    stall = 1'b1;
    cur   = '0;
    #1;
    check("stall0.int_we", int_we_o, 1'b0);
    tick();
    check("stall1.int_we", int_we_o, 1'b0);
    tick();
    stall = 1'b0;
    #1;
    check("unstall.int_we", int_we_o, 1'b1);
    check("unstall.int_wd", int_wd_o, 16'h0042);
    tick();
    check("after.int_we", int_we_o, 1'b0);
    checkAll("after_stall");

    // End instruction (with a jump too): its write lands, no redirect, halt.
    t = mk(1, 0, 1, 0, 4'd4, 2'd0, 8'h99, 64'h0, 64'h0, 0);
    t.en  = 1'b1;
    t.jmp = 1'b1;
    t.ja  = 10'h155;
    cur = t;
    tick();
    check("end.int_we", int_we_o, 1'b1);
    check("end.pc_sel", pc_sel_o, 1'b0);
    check("end.halted", halted_o, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cur = mk(1, 0, 1, 1, 4'd2, 2'd2, 8'h21, 64'h3, 64'h0, 0);
      tick();
      check($sformatf("halt%0d.halted", k), halted_o, 1'b1);
      check($sformatf("halt%0d.int_we", k), int_we_o, 1'b0);
      check($sformatf("halt%0d.vec_we", k), vec_we_o, 1'b0);
    end
    checkAll("halted");

    // Asynchronous reset between edges while squashing.
    doReset();
    t = mk(1, 0, 0, 0, 4'd0, 2'd0, 8'h00, 64'h0, 64'h0, 0);
    t.jmp = 1'b1;
    t.ja  = 10'h1AB;
    cur = t;
    tick();
    t = mk(1, 0, 1, 1, 4'hC, 2'd3, 8'h5A, 64'h1234_5678_9ABC_DEF0, 64'h0F0F, 0);
    t.ja = 10'h3FF;
    cur = t;
    tick();
    check("squash.int_dest", int_dest_o, 4'hC);
    #2;
    rst_i = 1'b0;
    modelReset();
    #1;
    check("arst.int_dest", int_dest_o, 4'h0);
    check("arst.int_wd", int_wd_o, 16'h0);
    check("arst.vec_wd", vec_wd_o, 64'h0);
    check("arst.pc_target", pc_target_o, 16'h0);
    check("arst.vec_dest", vec_dest_o, 2'd0);
    checkAll("arst");
    @(negedge clk_i);
    rst_i = 1'b1;
    cur = mk(1, 0, 1, 0, 4'd2, 2'd0, 8'h11, 64'h0, 64'h0, 0);
    tick();
    check("rel.int_we", int_we_o, 1'b1);
    check("rel.int_wd", int_wd_o, 16'h0011);
    check("rel.halted", halted_o, 1'b0);

    // Random traffic against the rule model.
    doReset();
    for (int n = 0; n < 600; n++) begin
      cur   = randInstr();
      stall = ($urandom_range(0, 3) == 0);
      #1;
      checkAll("rnd");
      tick();
      if (mHalted && $urandom_range(0, 5) == 0) doReset();
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
